imem_loader: RTL and testbench

Boot-time instruction-memory writer for the ARM pipeline. It accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and writes the bytes sequentially into the byte-addressed instruction ROM array. It holds the fetch stage until the load completes: `Hold` drives PC `LE` low and the CU mux to its NOP leg. It is the writing counterpart of the fetch path that reads ROM through `Register_PC`.

---
 rtl/imem_loader_pkg.sv | 31 +++
 rtl/xor_checksum.sv | 35 +++
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

   localparam int unsigned BYTE_W        = 8;
   localparam int unsigned ADDR_W        = 8;
   localparam int unsigned REM_W         = 9;
   localparam int unsigned WCNT_W        = 7;
   localparam int unsigned MAX_WORDS_DEF = 64;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN   = 3'd1,
      DATA  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   // One beat on the ROM byte write port.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [BYTE_W-1:0] data;
   } mem_wr_t;

   // A length byte is usable when it is non-zero and fits the ROM.
   function automatic logic len_ok(input logic [BYTE_W-1:0] n, input int unsigned max_words);
      return (n != '0) && (32'(n) <= max_words);
   endfunction

endpackage

// File: rtl/xor_checksum.sv
// Running XOR of accepted data bytes, with synchronous clear taking priority over enable.
module xor_checksum
   import imem_loader_pkg::*;
(
   input  logic              Clk,
   input  logic              Clr,
   input  logic              clear,
   input  logic              en,
   input  logic [BYTE_W-1:0] din,
   output logic [BYTE_W-1:0] sum
);

   logic [BYTE_W-1:0] sum_q;
   logic [BYTE_W-1:0] sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clear) begin
         sum_d = '0;
      end else if (en) begin
         sum_d = sum_q ^ din;
      end
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length-prefixed, XOR-checked byte stream and writes
// it sequentially into the instruction ROM while holding the fetch stage.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS = MAX_WORDS_DEF
)(
   input  logic              Clk,
   input  logic              Clr,
   input  logic              Start,
   input  logic [BYTE_W-1:0] In_Data,
   input  logic              In_Valid,
   output logic              In_Ready,
   output logic              Mem_WE,
   output logic [ADDR_W-1:0] Mem_A,
   output logic [BYTE_W-1:0] Mem_D,
   output logic              Hold,
   output logic              Done,
   output logic              Error,
   output logic [WCNT_W-1:0] Words_Loaded
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [WCNT_W-1:0] words_q, words_d;
   mem_wr_t           wr_q, wr_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic              ck_clear;
   logic              ck_en;
   logic [BYTE_W-1:0] ck_sum;
   logic              xfer_c;

   assign In_Ready = (state_q == LEN) || (state_q == DATA) || (state_q == CHECK);
   assign xfer_c   = In_Valid & In_Ready;

   xor_checksum u_xor_checksum (
      .Clk   (Clk),
      .Clr   (Clr),
      .clear (ck_clear),
      .en    (ck_en),
      .din   (In_Data),
      .sum   (ck_sum)
   );

   // Next-state, counters and write-port beat.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      words_d  = words_q;
      wr_d     = wr_q;
      wr_d.we  = 1'b0;
      ck_clear = 1'b0;
      ck_en    = 1'b0;

      case (state_q)
         IDLE, DONE, ERR: begin
            if (Start) begin
               state_d  = LEN;
               addr_d   = '0;
               rem_d    = '0;
               words_d  = '0;
               ck_clear = 1'b1;
            end
         end
         LEN: begin
            if (xfer_c) begin
               if (len_ok(In_Data, MAX_WORDS)) begin
                  rem_d   = REM_W'(In_Data) << 2;
                  state_d = DATA;
               end else begin
                  state_d = ERR;
               end
            end
         end
         DATA: begin
            if (xfer_c) begin
               wr_d.we   = 1'b1;
               wr_d.addr = addr_q;
               wr_d.data = In_Data;
               addr_d    = addr_q + ADDR_W'(1);
               rem_d     = rem_q - REM_W'(1);
               ck_en     = 1'b1;
               if (addr_q[1:0] == 2'b11) begin
                  words_d = words_q + WCNT_W'(1);
               end
               if (rem_q == REM_W'(1)) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (xfer_c) begin
               state_d = (In_Data == ck_sum) ? DONE : ERR;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags follow the state being entered so they land with it.
      hold_d  = (state_d != DONE);
      done_d  = (state_d == DONE);
      error_d = (state_d == ERR);
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         words_q <= '0;
         wr_q    <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         words_q <= words_d;
         wr_q    <= wr_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign Mem_WE       = wr_q.we;
   assign Mem_A        = wr_q.addr;
   assign Mem_D        = wr_q.data;
   assign Hold         = hold_q;
   assign Done         = done_q;
   assign Error        = error_q;
   assign Words_Loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader with a negedge write-capture model of the ROM.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       clr_n;
   logic       start;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       mem_we;
   logic [7:0] mem_a;
   logic [7:0] mem_d;
   logic       hold;
   logic       done;
   logic       error;
   logic [6:0] words_loaded;

   int n_tests = 0;
   int n_fail  = 0;

   imem_loader #(.MAX_WORDS(64)) dut (
      .Clk          (clk),
      .Clr          (clr_n),
      .Start        (start),
      .In_Data      (in_data),
      .In_Valid     (in_valid),
      .In_Ready     (in_ready),
      .Mem_WE       (mem_we),
      .Mem_A        (mem_a),
      .Mem_D        (mem_d),
      .Hold         (hold),
      .Done         (done),
      .Error        (error),
      .Words_Loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // ROM model: remembers each byte and the global write index that last touched it.
   logic [7:0] cap [256];
   int         stamp [256];
   int         wr_cnt = 0;
   int         last_a = -1;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         cap[mem_a]   <= mem_d;
         stamp[mem_a] <= wr_cnt + 1;
         wr_cnt       <= wr_cnt + 1;
         last_a       <= int'(mem_a);
      end
   end

   typedef struct {
      logic [7:0]  n;
      logic [63:0] pat;
      logic [7:0]  chk;
      bit          thr;
      int          glitch;
      bit          exp_done;
      int          exp_wr;
      logic [6:0]  exp_words;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] dbyte(input logic [63:0] pat, input int i);
      logic [63:0] p;
      p = pat;
      if (i < 8) return p[8*(7-i) +: 8];
      return 8'(i);
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_hold"},  32'(hold), 32'd1);
      chk({tag, "_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_we"},    32'(mem_we), 32'd0);
      chk({tag, "_a"},     32'(mem_a), 32'd0);
      chk({tag, "_d"},     32'(mem_d), 32'd0);
      chk({tag, "_done"},  32'(done), 32'd0);
      chk({tag, "_err"},   32'(error), 32'd0);
      chk({tag, "_words"}, 32'(words_loaded), 32'd0);
   endtask

   // Offer one byte; bounded wait for In_Ready, then one accepting edge.
   task automatic xfer(input logic [7:0] b, input bit st);
      int t;
      t        = 0;
      in_data  = b;
      in_valid = 1'b1;
      start    = st;
      while (in_ready !== 1'b1 && t < 16) begin
         @(posedge clk); #1;
         t++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int         wr_start;
      int         bad;
      int         nb;
      logic [7:0] b;
      wr_start = wr_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("v%0d_start_done", idx), 32'(done), 32'd0);
      chk($sformatf("v%0d_start_err", idx), 32'(error), 32'd0);
      chk($sformatf("v%0d_start_hold", idx), 32'(hold), 32'd1);
      chk($sformatf("v%0d_start_ready", idx), 32'(in_ready), 32'd1);
      xfer(v.n, 1'b0);
      if (v.n == 8'd0 || v.n > 8'd64) begin
         chk($sformatf("v%0d_len_err", idx), 32'(error), 32'd1);
         chk($sformatf("v%0d_len_hold", idx), 32'(hold), 32'd1);
         chk($sformatf("v%0d_len_ready", idx), 32'(in_ready), 32'd0);
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("v%0d_len_nowrites", idx), 32'(wr_cnt - wr_start), 32'd0);
      end else begin
         nb = 4 * int'(v.n);
         for (int i = 0; i < nb; i++) begin
            b = dbyte(v.pat, i);
            xfer(b, i == v.glitch);
            chk($sformatf("v%0d_wr_%0d", idx, i), {13'd0, mem_we, 2'd0, mem_a, mem_d},
                {13'd0, 1'b1, 2'd0, 8'(i), b});
            if (v.thr && (i % 3 == 2)) begin
               @(posedge clk); #1;
               chk($sformatf("v%0d_bubble_we_%0d", idx, i), 32'(mem_we), 32'd0);
            end
         end
         chk($sformatf("v%0d_check_ready", idx), 32'(in_ready), 32'd1);
         chk($sformatf("v%0d_pre_done", idx), 32'(done), 32'd0);
         xfer(v.chk, 1'b0);
         chk($sformatf("v%0d_done", idx), 32'(done), 32'(v.exp_done));
         chk($sformatf("v%0d_error", idx), 32'(error), 32'(!v.exp_done));
         chk($sformatf("v%0d_hold", idx), 32'(hold), 32'(!v.exp_done));
         chk($sformatf("v%0d_end_ready", idx), 32'(in_ready), 32'd0);
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("v%0d_words", idx), 32'(words_loaded), 32'(v.exp_words));
         chk($sformatf("v%0d_nwrites", idx), 32'(wr_cnt - wr_start), 32'(v.exp_wr));
         bad = 0;
         for (int i = 0; i < v.exp_wr; i++) begin
            if (stamp[i] <= wr_start || cap[i] !== dbyte(v.pat, i)) bad++;
         end
         chk($sformatf("v%0d_mem_bad", idx), 32'(bad), 32'd0);
         if (v.n == 8'd64) begin
            chk($sformatf("v%0d_last_a", idx), 32'(last_a), 32'd255);
         end
      end
   endtask

   initial begin
      // E3^A0^00^05 = 46, E2^81^10^01 = 72, 46^72 = 34; 01^02^03^04 = 04; XOR of 0..255 = 00.
      vecs[0] = '{8'd2,  64'hE3A00005_E2811001, 8'h34, 1'b0, -1, 1'b1, 8,   7'd2};
      vecs[1] = '{8'd2,  64'hE3A00005_E2811001, 8'h34, 1'b1, -1, 1'b1, 8,   7'd2};
      vecs[2] = '{8'd0,  64'h0,                 8'h00, 1'b0, -1, 1'b0, 0,   7'd0};
      vecs[3] = '{8'd65, 64'h0,                 8'h00, 1'b0, -1, 1'b0, 0,   7'd0};
      vecs[4] = '{8'd1,  64'h01020304_00000000, 8'h05, 1'b0, -1, 1'b0, 4,   7'd1};
      vecs[5] = '{8'd2,  64'hE3A00005_E2811001, 8'h34, 1'b0,  3, 1'b1, 8,   7'd2};
      vecs[6] = '{8'd64, 64'h00010203_04050607, 8'h00, 1'b0, -1, 1'b1, 256, 7'd64};

      clr_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #12;
      chk_reset_vals("por");
      @(negedge clk) clr_n = 1'b1;
      @(posedge clk); #1;

      // Start with a valid zero byte in IDLE: the byte must not be taken as N.
      in_data  = 8'h00;
      in_valid = 1'b1;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = 1'b0;
      chk("idle_start_err", 32'(error), 32'd0);
      chk("idle_start_ready", 32'(in_ready), 32'd1);

      // Abort a load mid-DATA with Clr.
      xfer(8'd2, 1'b0);
      xfer(8'h11, 1'b0);
      xfer(8'h22, 1'b0);
      xfer(8'h33, 1'b0);
      clr_n = 1'b0;
      #1;
      chk_reset_vals("clr_mid");
      @(posedge clk); #1;
      chk("clr_hold_held", 32'(hold), 32'd1);
      chk("clr_ready_held", 32'(in_ready), 32'd0);
      @(negedge clk) clr_n = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 7; k++) begin
         run_vec(vecs[k], k);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
